// File: rtl/wb_pkg.sv
// Shared Wishbone master types: core command encoding and master FSM states.
package wb_pkg;

  localparam int unsigned WB_ADDR_WIDTH = 32;
  localparam int unsigned WB_DATA_WIDTH = 32;

  // 2'b11 is not a legal command and is treated like NONE by the master.
  typedef enum logic [1:0] {
    NONE  = 2'b00,
    LOAD  = 2'b01,
    STORE = 2'b10
  } wb_command_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } wb_state_t;

endpackage

// File: rtl/wb_bus_master_if.sv
// Wishbone B4 classic bus signals between the core's bus master and a slave.
interface wb_bus_master_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                    cyc;
  logic                    stb;
  logic                    we;
  logic [ADDR_WIDTH-1:0]   adr;
  logic [DATA_WIDTH-1:0]   dat_w;
  logic [DATA_WIDTH/8-1:0] sel;
  logic [DATA_WIDTH-1:0]   dat_r;
  logic                    ack;
  logic                    err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_bus_master.sv
// Single-outstanding Wishbone B4 classic master: turns one-cycle LOAD/STORE
// commands from the core into bus cycles and reports completion via busy_out.
module wb_bus_master
  import wb_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = WB_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = WB_DATA_WIDTH
) (
  input  logic                    clk_in,
  input  logic                    reset_in,
  input  wb_command_t             cmd_in,
  output logic                    busy_out,
  output logic [DATA_WIDTH-1:0]   rdata_out,
  input  logic [DATA_WIDTH-1:0]   wdata_in,
  input  logic [DATA_WIDTH/8-1:0] wmask_in,
  input  logic [ADDR_WIDTH-1:0]   addr_in,
  wb_bus_master_if.master         wb
);

  localparam int unsigned SEL_WIDTH = DATA_WIDTH / 8;

  wb_state_t             state, state_next;
  logic                  cyc_q, cyc_next;
  logic                  stb_q, stb_next;
  logic                  we_q, we_next;
  logic [ADDR_WIDTH-1:0] adr_q, adr_next;
  logic [DATA_WIDTH-1:0] dat_q, dat_next;
  logic [SEL_WIDTH-1:0]  sel_q, sel_next;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_next;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state   <= IDLE;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_next;
      cyc_q   <= cyc_next;
      stb_q   <= stb_next;
      we_q    <= we_next;
      adr_q   <= adr_next;
      dat_q   <= dat_next;
      sel_q   <= sel_next;
      rdata_q <= rdata_next;
    end
  end

  always_comb begin
    state_next = state;
    cyc_next   = cyc_q;
    stb_next   = stb_q;
    we_next    = we_q;
    adr_next   = adr_q;
    dat_next   = dat_q;
    sel_next   = sel_q;
    rdata_next = rdata_q;

    unique case (state)
      IDLE: begin
        case (cmd_in)
          LOAD: begin
            state_next = ACTIVE;
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
            we_next    = 1'b0;
            adr_next   = addr_in;
            dat_next   = '0;
            sel_next   = '1;
          end
          STORE: begin
            state_next = ACTIVE;
            cyc_next   = 1'b1;
            stb_next   = 1'b1;
            we_next    = 1'b1;
            adr_next   = addr_in;
            dat_next   = wdata_in;
            sel_next   = wmask_in;
          end
          default: ;
        endcase
      end
      ACTIVE: begin
        // ERR takes priority over a simultaneous ACK; the registered WE
        // still identifies the outstanding transfer as a load or store.
        if (wb.ack || wb.err) begin
          state_next = IDLE;
          cyc_next   = 1'b0;
          stb_next   = 1'b0;
          we_next    = 1'b0;
          if (!we_q) begin
            rdata_next = wb.err ? '0 : wb.dat_r;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy_out  = (state == ACTIVE);
  assign rdata_out = rdata_q;

  assign wb.cyc   = cyc_q;
  assign wb.stb   = stb_q;
  assign wb.we    = we_q;
  assign wb.adr   = adr_q;
  assign wb.dat_w = dat_q;
  assign wb.sel   = sel_q;

endmodule

// File: tb/tb_wb_bus_master.sv
// Scenario bench for wb_bus_master: each task drives one feature and checks
// bus signals inline; expected read data flows through a scoreboard queue.
module tb_wb_bus_master;
  import wb_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  wb_command_t cmd;
  logic [31:0] wdata;
  logic [3:0]  wmask;
  logic [31:0] addr;
  logic        busy;
  logic [31:0] rdata;

  wb_bus_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wb ();

  wb_bus_master #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_in    (clk),
    .reset_in  (rst),
    .cmd_in    (cmd),
    .busy_out  (busy),
    .rdata_out (rdata),
    .wdata_in  (wdata),
    .wmask_in  (wmask),
    .addr_in   (addr),
    .wb        (wb)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_rdata = 32'h0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues one command at posedge+1 and plays the slave: ACK/ERR after `waits`
  // wait states. Returns what the bus looked like while the transfer was open.
  task automatic do_txn(input wb_command_t c, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] wm, input int waits, input bit use_err,
                        input bit both, input logic [31:0] sdata, input wb_command_t busy_cmd,
                        output int bc, output bit stable, output logic [31:0] cap_adr,
                        output logic [31:0] cap_dat, output logic [3:0] cap_sel,
                        output bit cap_we, output bit cap_cs);
    logic [31:0] e;
    cmd = c; addr = a; wdata = wd; wmask = wm;
    if (c == LOAD) e = (use_err || both) ? 32'h0 : sdata;
    else           e = model_rdata;
    model_rdata = e;
    exp_q.push_back(e);
    @(posedge clk); #1;
    cmd = busy_cmd;
    addr = $urandom; wdata = $urandom; wmask = 4'($urandom);
    cap_adr = wb.adr; cap_dat = wb.dat_w; cap_sel = wb.sel;
    cap_we = wb.we; cap_cs = wb.cyc && wb.stb;
    bc = 0; stable = 1'b1;
    for (int i = 0; i <= waits; i++) begin
      if (busy) bc++;
      if (wb.adr !== cap_adr || wb.dat_w !== cap_dat || wb.sel !== cap_sel ||
          wb.we !== cap_we || !(wb.cyc && wb.stb)) stable = 1'b0;
      if (i == waits) begin
        wb.ack = !use_err || both; wb.err = use_err || both; wb.dat_r = sdata;
      end
      @(posedge clk); #1;
    end
    wb.ack = 1'b0; wb.err = 1'b0; wb.dat_r = $urandom;
    cmd = NONE;
  endtask

  task automatic test_reset();
    rst = 1'b1; cmd = NONE; addr = '0; wdata = '0; wmask = '0;
    wb.ack = 1'b0; wb.err = 1'b0; wb.dat_r = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    n_assert++;
    if ({busy, wb.cyc, wb.stb, wb.we} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_ctrl: busy/cyc/stb/we=%b expected 0000", {busy, wb.cyc, wb.stb, wb.we});
    end
    n_assert++;
    if (wb.adr !== 32'h0 || wb.dat_w !== 32'h0 || wb.sel !== 4'h0) begin
      n_fail++; $display("FAIL reset_bus: adr=%h dat=%h sel=%h expected zeros", wb.adr, wb.dat_w, wb.sel);
    end
    n_assert++;
    if (rdata !== 32'h0) begin
      n_fail++; $display("FAIL reset_rdata: got %h expected 00000000", rdata);
    end
    rst = 1'b0;
    model_rdata = 32'h0;
    @(posedge clk); #1;
  endtask

  task automatic test_idle_none();
    cmd = NONE; addr = 32'h40;
    @(posedge clk); #1;
    n_assert++;
    if (busy !== 1'b0 || wb.cyc !== 1'b0) begin
      n_fail++; $display("FAIL idle_none: busy=%b cyc=%b expected 0 0", busy, wb.cyc);
    end
    cmd = wb_command_t'(2'b11);
    @(posedge clk); #1;
    cmd = NONE;
    n_assert++;
    if (busy !== 1'b0 || wb.cyc !== 1'b0) begin
      n_fail++; $display("FAIL idle_cmd11: busy=%b cyc=%b expected 0 0", busy, wb.cyc);
    end
  endtask

  task automatic test_load_ack();
    int bc; bit st, we, cs; logic [31:0] ad, dt; logic [3:0] sl; logic [31:0] e;
    do_txn(LOAD, 32'h100, 32'h5555_AAAA, 4'h1, 0, 1'b0, 1'b0, 32'hDEAD_BEEF, NONE,
           bc, st, ad, dt, sl, we, cs);
    n_assert++;
    if (bc !== 1) begin n_fail++; $display("FAIL load_busy_len: got %0d expected 1", bc); end
    n_assert++;
    if (ad !== 32'h100 || sl !== 4'hF || we !== 1'b0 || dt !== 32'h0 || cs !== 1'b1) begin
      n_fail++; $display("FAIL load_bus: adr=%h sel=%h we=%b dat=%h cs=%b expected 00000100 f 0 00000000 1", ad, sl, we, dt, cs);
    end
    n_assert++;
    if (busy !== 1'b0 || wb.cyc !== 1'b0 || wb.stb !== 1'b0) begin
      n_fail++; $display("FAIL load_end: busy=%b cyc=%b stb=%b expected 0 0 0", busy, wb.cyc, wb.stb);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (rdata !== e) begin n_fail++; $display("FAIL load_rdata: got %h expected %h", rdata, e); end
  endtask

  task automatic test_store_waits();
    int bc; bit st, we, cs; logic [31:0] ad, dt; logic [3:0] sl; logic [31:0] e;
    @(posedge clk); #1;
    do_txn(STORE, 32'h204, 32'h1234_5678, 4'b0011, 3, 1'b0, 1'b0, 32'h0BAD_0BAD, NONE,
           bc, st, ad, dt, sl, we, cs);
    n_assert++;
    if (bc !== 4) begin n_fail++; $display("FAIL store_busy_len: got %0d expected 4", bc); end
    n_assert++;
    if (st !== 1'b1) begin n_fail++; $display("FAIL store_stable: got %b expected 1", st); end
    n_assert++;
    if (ad !== 32'h204 || sl !== 4'b0011 || we !== 1'b1 || dt !== 32'h1234_5678) begin
      n_fail++; $display("FAIL store_bus: adr=%h sel=%h we=%b dat=%h expected 00000204 3 1 12345678", ad, sl, we, dt);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (rdata !== e || busy !== 1'b0) begin
      n_fail++; $display("FAIL store_rdata: rdata=%h busy=%b expected %h 0", rdata, busy, e);
    end
  endtask

  task automatic test_cmd_while_busy();
    int bc; bit st, we, cs; logic [31:0] ad, dt; logic [3:0] sl; logic [31:0] e;
    int extra_cyc;
    @(posedge clk); #1;
    do_txn(LOAD, 32'h300, 32'h0, 4'h0, 2, 1'b0, 1'b0, 32'hA5A5_0F0F, STORE,
           bc, st, ad, dt, sl, we, cs);
    n_assert++;
    if (bc !== 3 || we !== 1'b0 || st !== 1'b1) begin
      n_fail++; $display("FAIL busy_cmd_txn: busy_len=%0d we=%b stable=%b expected 3 0 1", bc, we, st);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (rdata !== e) begin n_fail++; $display("FAIL busy_cmd_rdata: got %h expected %h", rdata, e); end
    extra_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (wb.cyc || busy) extra_cyc++;
      @(posedge clk); #1;
    end
    n_assert++;
    if (extra_cyc !== 0) begin
      n_fail++; $display("FAIL busy_cmd_queued: extra bus cycles=%0d expected 0", extra_cyc);
    end
  endtask

  task automatic test_bus_error();
    int bc; bit st, we, cs; logic [31:0] ad, dt; logic [3:0] sl; logic [31:0] e;
    @(posedge clk); #1;
    do_txn(LOAD, 32'h400, 32'h0, 4'h0, 1, 1'b1, 1'b0, 32'h1111_2222, NONE,
           bc, st, ad, dt, sl, we, cs);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (busy !== 1'b0 || rdata !== e) begin
      n_fail++; $display("FAIL err_load: busy=%b rdata=%h expected 0 %h", busy, rdata, e);
    end
    do_txn(LOAD, 32'h404, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h7777_8888, NONE,
           bc, st, ad, dt, sl, we, cs);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (rdata !== e) begin n_fail++; $display("FAIL err_reload: got %h expected %h", rdata, e); end
    do_txn(LOAD, 32'h408, 32'h0, 4'h0, 0, 1'b0, 1'b1, 32'h9999_AAAA, NONE,
           bc, st, ad, dt, sl, we, cs);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (busy !== 1'b0 || rdata !== e) begin
      n_fail++; $display("FAIL ack_err_both: busy=%b rdata=%h expected 0 %h", busy, rdata, e);
    end
  endtask

  task automatic test_reset_mid();
    int bc; bit st, we, cs; logic [31:0] ad, dt; logic [3:0] sl; logic [31:0] e;
    @(posedge clk); #1;
    cmd = LOAD; addr = 32'h500;
    @(posedge clk); #1;
    cmd = NONE;
    @(posedge clk); #1;
    n_assert++;
    if (busy !== 1'b1 || wb.cyc !== 1'b1) begin
      n_fail++; $display("FAIL rst_mid_active: busy=%b cyc=%b expected 1 1", busy, wb.cyc);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_rdata = 32'h0;
    n_assert++;
    if ({wb.cyc, wb.stb, busy} !== 3'b000 || rdata !== 32'h0) begin
      n_fail++; $display("FAIL rst_mid_drop: cyc/stb/busy=%b rdata=%h expected 000 00000000", {wb.cyc, wb.stb, busy}, rdata);
    end
    @(posedge clk); #1;
    do_txn(LOAD, 32'h504, 32'h0, 4'h0, 1, 1'b0, 1'b0, 32'hCAFE_F00D, NONE,
           bc, st, ad, dt, sl, we, cs);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (ad !== 32'h504 || bc !== 2 || rdata !== e) begin
      n_fail++; $display("FAIL rst_mid_after: adr=%h busy_len=%0d rdata=%h expected 00000504 2 %h", ad, bc, rdata, e);
    end
  endtask

  task automatic test_back_to_back();
    int bc; bit st, we, cs; logic [31:0] ad, dt; logic [3:0] sl; logic [31:0] e;
    @(posedge clk); #1;
    do_txn(LOAD, 32'h600, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0102_0304, NONE,
           bc, st, ad, dt, sl, we, cs);
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (rdata !== e) begin n_fail++; $display("FAIL b2b_first: got %h expected %h", rdata, e); end
    do_txn(LOAD, 32'h604, 32'h0, 4'h0, 0, 1'b0, 1'b0, 32'h0506_0708, NONE,
           bc, st, ad, dt, sl, we, cs);
    n_assert++;
    if (cs !== 1'b1 || ad !== 32'h604 || bc !== 1) begin
      n_fail++; $display("FAIL b2b_second: cs=%b adr=%h busy_len=%0d expected 1 00000604 1", cs, ad, bc);
    end
    e = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hxxxx_xxxx;
    n_assert++;
    if (rdata !== e) begin n_fail++; $display("FAIL b2b_rdata: got %h expected %h", rdata, e); end
  endtask

  initial begin
    test_reset();
    test_idle_none();
    test_load_ack();
    test_store_waits();
    test_cmd_while_busy();
    test_bus_error();
    test_reset_mid();
    test_back_to_back();
    n_assert++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
